mult_arbiter_ctrl: RTL and testbench
====================================

# mult_arbiter_ctrl

Round-robin controller that shares one sequential shift-add 4x4 unsigned multiplier among several requesters (switch banks, host logic, test sequencer). Each requester presents operands with a valid/ready handshake. The block arbitrates, sequences the multiplier over WIDTH cycles, and returns the tagged product with a one-cycle response strobe. It sits between the operand sources and the product/seven-segment display path, replacing the single-user load/reset multiplier control.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits
- IDW, 2, requester-id width, clog2(NREQ), minimum 1
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i: requester i has an operand pair pending
- req_a  in  NREQ*WIDTH  multiplicands, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  multipliers, same packing
- req_ready  out  NREQ  one-hot accept strobe; transfer when req_valid[i] & req_ready[i]
- rsp_valid  out  1  one-cycle product strobe
- rsp_data  out  2*WIDTH  unsigned product a*b, held until next response
- rsp_id  out  IDW  index of the requester that owns rsp_data, held with it
- busy  out  1  high in CALC and DONE

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if any req_valid is set, a combinational round-robin pick g is made. req_ready[g]=1 in that same cycle. On the edge: latch a=req_a[g] and b=req_b[g], set acc=0, cnt=0, store id=g, set ptr=(g+1) mod NREQ, then go to CALC. With no valid, stay in IDLE and keep req_ready=0.
- Round-robin order: search starts at ptr and wraps. After reset ptr=0, so requester 0 has highest priority.
- CALC: one multiplier bit per cycle, LSB first. acc is 2*WIDTH+1 bits.
  - If b[0]=1, the upper WIDTH+1 bits become upper + a.
  - Then acc shifts right 1, b shifts right 1, and cnt increments.
  - After WIDTH iterations (cnt==WIDTH-1 on the edge), go to DONE.
- DONE: rsp_valid=1, rsp_data=acc[2*WIDTH-1:0], rsp_id=id. Return to IDLE on the next edge.
- req_ready stays 0 in CALC and DONE. New requests wait in IDLE and are never lost, as long as the requester holds valid.
- Requester rules:
  - Hold req_valid, req_a and req_b stable until it sees req_ready.
  - Dropping req_valid before grant is legal and simply removes it from arbitration.
  - Operand changes after the accept edge do not affect the result in flight.
- Arithmetic: unsigned, exact. The maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits with no overflow. The extra acc bit only holds the carry before the shift.
- Reset values: state=IDLE, ptr=0, acc=0, cnt=0, id=0; req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
- Reset mid-operation: asserting rst_n low in CALC or DONE aborts immediately with no response. Outputs go to their reset values.
- Deassertion of rst_n is synchronised externally; the block sees it as a clean edge.

## Timing
- Accept edge T (req_valid & req_ready high in cycle T-1 → sampled at edge T). State is CALC for cycles T..T+WIDTH-1, DONE in cycle T+WIDTH. rsp_valid is high for exactly that one cycle.
- Latency from accept edge to rsp_valid: WIDTH cycles (4 at default).
- Back-to-back throughput: one product per WIDTH+2 cycles (IDLE accept, WIDTH CALC, DONE). This is 6 cycles at default.
- req_ready is a combinational function of state, ptr and req_valid. It has no path from req_a or req_b.
- rsp_data and rsp_id are registered and stable from the DONE cycle until the next DONE.
- busy is registered and equals (state != IDLE).

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 → req_ready=0, rsp_valid=0, rsp_data=0x00, busy=0. Release → first grant goes to requester 0.
- Single request: requester 2 sends a=7, b=9 → req_ready[2] pulses once, and rsp_valid arrives 4 cycles after the accept edge with rsp_data=0x3F (63), rsp_id=2.
- Corners: test 15*15 → 0xE1, 0*13 → 0x00, 13*0 → 0x00, 1*15 → 0x0F, 8*8 → 0x40. Exhaustive 256-pair sweep on requester 0 against a reference model.
- Fairness: hold all four req_valid high continuously → grant order 0,1,2,3,0,1. rsp_id follows the same order, one response every 6 cycles.
- Sparse/withdraw: requesters 1 and 3 valid, last grant was 1 → next grant 3. Requester 3 withdraws before its turn → next grant returns to 1, and no response ever carries id 3.
- Abort: assert rst_n low 2 cycles into CALC → no rsp_valid. After release, the same pending request is re-granted to requester 0 first and completes with the correct product.

Source files
------------

// File: rtl/mult_arbiter_ctrl_if.sv
// Requester-side handshake and product-response bundle for the shared
// multiplier controller.
interface mult_arbiter_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/mult_arbiter_ctrl.sv
// Round-robin arbiter in front of one sequential shift-add multiplier; each
// accepted operand pair returns a tagged product WIDTH cycles later.
module mult_arbiter_ctrl #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_arbiter_ctrl_if.slave  bus
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, id_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH:0]     acc_q;
  logic [CNTW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   rsp_data_q;
  logic [IDW-1:0]       rsp_id_q;
  logic                 busy_q;

  logic                 hi_any, lo_any, grant_any;
  logic [IDW-1:0]       hi_idx, lo_idx, grant_idx;
  logic [WIDTH-1:0]     a_sel, b_sel;
  logic [2*WIDTH:0]     acc_add, acc_step;
  logic                 last_bit;

  // Rotating priority: lowest valid index at or above ptr wins, otherwise the
  // lowest valid index overall (the wrapped part of the search).
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_any = 1'b1;
        lo_idx = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          hi_any = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
    grant_any = lo_any;
    grant_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is forced low while reset is held so no transfer is signalled then.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state_q == IDLE && grant_any) begin
      bus.req_ready = NREQ'(1) << grant_idx;
    end
  end

  // One shift-add step: conditionally add a into the upper WIDTH+1 bits, then
  // shift right. The extra acc bit only ever holds the carry of that add.
  always_comb begin
    acc_add = acc_q;
    if (b_q[0]) begin
      acc_add = {acc_q[2*WIDTH:WIDTH] + {1'b0, a_q}, acc_q[WIDTH-1:0]};
    end
    acc_step = acc_add >> 1;
    last_bit = (cnt_q == CNTW'(WIDTH - 1));
  end

  always_comb begin
    state_d       = state_q;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: if (grant_any) state_d = CALC;
      CALC: if (last_bit)  state_d = DONE;
      DONE: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the datapath registers are reset as well, so an abort leaves no stale
  // product visible on rsp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q   <= a_sel;
            b_q   <= b_sel;
            acc_q <= '0;
            cnt_q <= '0;
            id_q  <= grant_idx;
            ptr_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        CALC: begin
          acc_q <= acc_step;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            rsp_data_q <= acc_step[2*WIDTH-1:0];
            rsp_id_q   <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_id   = rsp_id_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mult_arbiter_ctrl.sv
// Directed bench for mult_arbiter_ctrl: a cycle-level transaction model is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_mult_arbiter_ctrl;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;
  localparam int LAT   = WIDTH;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  typedef struct {
    int id;
    int data;
    int cyc;
  } rec_t;

  rec_t grant_q[$];
  rec_t rsp_q[$];

  // Model: phase 0 = waiting, 1..WIDTH = computing, WIDTH+1 = response cycle.
  int m_phase, m_ptr, m_prod, m_id, m_data, m_rid;

  mult_arbiter_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  mult_arbiter_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int op_of(input logic [NREQ*WIDTH-1:0] vec, input int idx);
    int r;
    r = 0;
    for (int i = 0; i < NREQ; i++) if (i == idx) r = int'(vec[i*WIDTH +: WIDTH]);
    return r;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready;
    int g;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_data = 0; m_rid = 0;
    end
    g = m_pick();
    e_ready = '0;
    if (rst_n && m_phase == 0 && g >= 0) e_ready[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(e_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(rst_n && m_phase == LAT + 1));
    check("busy",      32'(bus.busy),      32'(rst_n && m_phase != 0));
    check("rsp_data",  32'(bus.rsp_data),  m_data);
    check("rsp_id",    32'(bus.rsp_id),    m_rid);
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) grant_q.push_back('{i, 0, cyc});
      if (bus.rsp_valid) rsp_q.push_back('{int'(bus.rsp_id), int'(bus.rsp_data), cyc});
      if (m_phase == 0) begin
        if (g >= 0) begin
          m_prod  = op_of(bus.req_a, g) * op_of(bus.req_b, g);
          m_id    = g;
          m_ptr   = (g + 1) % NREQ;
          m_phase = 1;
        end
      end else if (m_phase <= LAT) begin
        m_phase++;
        if (m_phase == LAT + 1) begin
          m_data = m_prod;
          m_rid  = m_id;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input int a, input int b);
    bus.req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Returns in the middle of the cycle in which the n-th grant was seen.
  task automatic wait_grants(input int n);
    for (int i = 0; i < 60 && grant_q.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    if (grant_q.size() < n) check("grant_timeout", grant_q.size(), n);
  endtask

  task automatic wait_rsps(input int n);
    for (int i = 0; i < 60 && rsp_q.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    if (rsp_q.size() < n) check("rsp_timeout", rsp_q.size(), n);
    next_cycle();
  endtask

  task automatic do_req(input int id, input int a, input int b, input int exp);
    int g0, r0;
    g0 = grant_q.size();
    r0 = rsp_q.size();
    set_ops(id, a, b);
    bus.req_valid[id] = 1'b1;
    wait_grants(g0 + 1);
    next_cycle();
    bus.req_valid[id] = 1'b0;
    wait_rsps(r0 + 1);
    if (rsp_q.size() > r0) begin
      check($sformatf("product_%0dx%0d", a, b), rsp_q[r0].data, exp);
      check("product_id", rsp_q[r0].id, id);
    end
  endtask

  typedef struct { int a; int b; int p; } corner_t;
  corner_t corners[5] = '{'{15, 15, 'hE1}, '{0, 13, 'h00}, '{13, 0, 'h00},
                          '{1, 15, 'h0F}, '{8, 8, 'h40}};
  int fair_ids[6]  = '{0, 1, 2, 3, 0, 1};
  int fair_data[6] = '{10, 18, 28, 40, 10, 18};

  initial begin
    cyc = 0; n_checks = 0; n_err = 0;
    m_phase = 0; m_ptr = 0; m_prod = 0; m_id = 0; m_data = 0; m_rid = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // Reset with every requester asking, then fairness under continuous load.
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 2, i + 5);
    bus.req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", 32'(bus.req_ready), 0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_rsp_data", 32'(bus.rsp_data), 0);
    check("reset_busy", 32'(bus.busy), 0);
    next_cycle();
    rst_n = 1'b1;
    wait_grants(6);
    next_cycle();
    bus.req_valid = '0;
    wait_rsps(6);
    for (int k = 0; k < 6 && k < grant_q.size(); k++) check("fair_grant", grant_q[k].id, fair_ids[k]);
    for (int k = 0; k < 6 && k < rsp_q.size(); k++) begin
      check("fair_rsp_id", rsp_q[k].id, fair_ids[k]);
      check("fair_rsp_data", rsp_q[k].data, fair_data[k]);
      if (k > 0) check("fair_spacing", rsp_q[k].cyc - rsp_q[k-1].cyc, WIDTH + 2);
    end

    // Single request with latency measurement.
    grant_q.delete(); rsp_q.delete();
    do_req(2, 7, 9, 'h3F);
    check("single_grants", grant_q.size(), 1);
    if (grant_q.size() > 0 && rsp_q.size() > 0)
      check("single_latency", rsp_q[0].cyc - (grant_q[0].cyc + 1), 4);

    // Corner operands and the full sweep on requester 0.
    foreach (corners[k]) do_req(0, corners[k].a, corners[k].b, corners[k].p);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) do_req(0, a, b, a * b);

    // Sparse: requesters 1 and 3 both waiting, 1 wins first then 3.
    grant_q.delete(); rsp_q.delete();
    set_ops(1, 3, 5);
    set_ops(3, 6, 7);
    bus.req_valid = 4'b1010;
    wait_grants(2);
    next_cycle();
    bus.req_valid = '0;
    wait_rsps(2);
    if (grant_q.size() >= 2) begin
      check("sparse_first", grant_q[0].id, 1);
      check("sparse_second", grant_q[1].id, 3);
    end
    if (rsp_q.size() >= 2) begin
      check("sparse_p1", rsp_q[0].data, 15);
      check("sparse_p3", rsp_q[1].data, 42);
    end

    // Withdraw: 3 drops out while 1 is computing; 1 is served next, never 3.
    grant_q.delete(); rsp_q.delete();
    set_ops(1, 2, 9);
    bus.req_valid = 4'b0010;
    wait_grants(1);
    next_cycle();
    set_ops(1, 4, 4);
    set_ops(3, 5, 5);
    bus.req_valid = 4'b1010;
    repeat (2) next_cycle();
    bus.req_valid[3] = 1'b0;
    wait_grants(2);
    next_cycle();
    bus.req_valid = '0;
    wait_rsps(2);
    repeat (8) next_cycle();
    if (grant_q.size() >= 2) check("withdraw_next", grant_q[1].id, 1);
    if (rsp_q.size() >= 2) begin
      check("withdraw_p_held", rsp_q[0].data, 18);
      check("withdraw_p_new", rsp_q[1].data, 16);
    end
    foreach (rsp_q[k]) check("withdraw_no_id3", 32'(rsp_q[k].id == 3), 0);

    // Abort two cycles into the computation, then the same request completes.
    grant_q.delete(); rsp_q.delete();
    set_ops(0, 11, 6);
    bus.req_valid = 4'b0001;
    wait_grants(1);
    repeat (2) next_cycle();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    wait_grants(2);
    next_cycle();
    bus.req_valid = '0;
    wait_rsps(1);
    repeat (8) next_cycle();
    check("abort_rsp_count", rsp_q.size(), 1);
    if (grant_q.size() >= 2) check("abort_regrant", grant_q[1].id, 0);
    if (rsp_q.size() >= 1) begin
      check("abort_product", rsp_q[0].data, 66);
      check("abort_id", rsp_q[0].id, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
